// File: rtl/letter_pool_if.sv
// Bundle of spawn, keystroke, frame tick, slot read and score event signals
// shared between letter_pool and its neighbours.
interface letter_pool_if #(
    parameter int IDX_W = 3
);
    logic             spawn;
    logic [7:0]       gen_ch;
    logic [2:0]       gen_speed;
    logic [8:0]       gen_x;
    logic [9:0]       gen_y;
    logic             frame_tick;
    logic             key_valid;
    logic [7:0]       key_ch;
    logic             key_ready;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_active;
    logic [7:0]       rd_ch;
    logic [8:0]       rd_x;
    logic [9:0]       rd_y;
    logic             hit;
    logic             miss;
    logic             escape;
    logic             overflow;
    logic [IDX_W:0]   active_cnt;

    modport master (
        output spawn, gen_ch, gen_speed, gen_x, gen_y, frame_tick,
               key_valid, key_ch, rd_idx,
        input  key_ready, rd_active, rd_ch, rd_x, rd_y,
               hit, miss, escape, overflow, active_cnt
    );

    modport slave (
        input  spawn, gen_ch, gen_speed, gen_x, gen_y, frame_tick,
               key_valid, key_ch, rd_idx,
        output key_ready, rd_active, rd_ch, rd_x, rd_y,
               hit, miss, escape, overflow, active_cnt
    );
endinterface

// File: rtl/letter_pool.sv
// Pool of falling letters: captures spawns, moves letters each frame tick,
// resolves keystrokes against the lowest matching letter, reports events.
module letter_pool #(
    parameter int SLOTS = 8,
    parameter int IDX_W = 3,
    parameter int X_MAX = 471
) (
    input logic          clk,
    input logic          rst_n,
    letter_pool_if.slave bus
);
    typedef enum logic [2:0] {IDLE, KEY_SCAN, KEY_RESOLVE, MOVE, SPAWN} state_t;

    localparam logic [9:0]       X_LIM = 10'(X_MAX);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(SLOTS - 1);

    state_t state, state_nxt;

    logic [SLOTS-1:0] act;
    logic [7:0]       ch  [SLOTS];
    logic [2:0]       spd [SLOTS];
    logic [8:0]       xs  [SLOTS];
    logic [9:0]       ys  [SLOTS];

    logic       key_pend, tick_pend, spawn_pend;
    logic [7:0] key_lat;
    logic [7:0] sp_ch;
    logic [2:0] sp_speed;
    logic [8:0] sp_x;
    logic [9:0] sp_y;

    logic [IDX_W-1:0] scan_idx, best_idx;
    logic             found;
    logic [8:0]       best_x;

    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic [9:0]       new_x [SLOTS];
    logic [SLOTS-1:0] esc;
    logic [IDX_W:0]   cnt;

    logic hit_q, miss_q, escape_q, overflow_q;

    // Event capture; a fresh event on the clearing edge wins so none is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_pend   <= 1'b0;
            tick_pend  <= 1'b0;
            spawn_pend <= 1'b0;
            key_lat    <= '0;
            sp_ch      <= '0;
            sp_speed   <= '0;
            sp_x       <= '0;
            sp_y       <= '0;
        end else begin
            if (bus.key_valid && !key_pend) begin
                key_pend <= 1'b1;
                key_lat  <= bus.key_ch;
            end else if (state == KEY_RESOLVE) begin
                key_pend <= 1'b0;
            end

            if (bus.frame_tick)
                tick_pend <= 1'b1;
            else if (state == MOVE)
                tick_pend <= 1'b0;

            if (bus.spawn) begin
                spawn_pend <= 1'b1;
                sp_ch      <= bus.gen_ch;
                sp_speed   <= bus.gen_speed;
                sp_x       <= bus.gen_x;
                sp_y       <= bus.gen_y;
            end else if (state == SPAWN) begin
                spawn_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (key_pend)
                    state_nxt = KEY_SCAN;
                else if (tick_pend)
                    state_nxt = MOVE;
                else if (spawn_pend)
                    state_nxt = SPAWN;
            end
            KEY_SCAN: begin
                if (scan_idx == LAST)
                    state_nxt = KEY_RESOLVE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strict '>' keeps the lower index on equal rows since the scan ascends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_idx <= '0;
            best_idx <= '0;
            best_x   <= '0;
            found    <= 1'b0;
        end else if (state == KEY_SCAN) begin
            scan_idx <= scan_idx + 1'b1;
            if (act[scan_idx] && ch[scan_idx] == key_lat &&
                (!found || xs[scan_idx] > best_x)) begin
                found    <= 1'b1;
                best_idx <= scan_idx;
                best_x   <= xs[scan_idx];
            end
        end else if (state == IDLE) begin
            scan_idx <= '0;
            best_idx <= '0;
            best_x   <= '0;
            found    <= 1'b0;
        end
    end

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = SLOTS; i > 0; i--) begin
            if (!act[i-1]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i - 1);
            end
        end
    end

    always_comb begin
        esc = '0;
        cnt = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            new_x[i] = {1'b0, xs[i]} + {7'b0, spd[i]};
            esc[i]   = act[i] && (new_x[i] > X_LIM);
            cnt      = cnt + {{IDX_W{1'b0}}, act[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act        <= '0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            escape_q   <= 1'b0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < SLOTS; i++) begin
                ch[i]  <= '0;
                spd[i] <= '0;
                xs[i]  <= '0;
                ys[i]  <= '0;
            end
        end else begin
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            escape_q   <= 1'b0;
            overflow_q <= 1'b0;
            unique case (state)
                KEY_RESOLVE: begin
                    if (found) begin
                        act[best_idx] <= 1'b0;
                        hit_q         <= 1'b1;
                    end else begin
                        miss_q <= 1'b1;
                    end
                end
                MOVE: begin
                    for (int unsigned i = 0; i < SLOTS; i++) begin
                        if (esc[i])
                            act[i] <= 1'b0;
                        else if (act[i])
                            xs[i] <= new_x[i][8:0];
                    end
                    escape_q <= |esc;
                end
                SPAWN: begin
                    if (free_found) begin
                        act[free_idx] <= 1'b1;
                        ch[free_idx]  <= sp_ch;
                        spd[free_idx] <= sp_speed;
                        xs[free_idx]  <= sp_x;
                        ys[free_idx]  <= sp_y;
                    end else begin
                        overflow_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.key_ready  = !key_pend;
    assign bus.rd_active  = act[bus.rd_idx];
    assign bus.rd_ch      = ch[bus.rd_idx];
    assign bus.rd_x       = xs[bus.rd_idx];
    assign bus.rd_y       = ys[bus.rd_idx];
    assign bus.hit        = hit_q;
    assign bus.miss       = miss_q;
    assign bus.escape     = escape_q;
    assign bus.overflow   = overflow_q;
    assign bus.active_cnt = cnt;
endmodule
